hdlc_rx_deframer: RTL and testbench

//  Serial front end of the HDLC receive path. It sits between the Rx pin and the Rx

---
 rtl/hdlc_rx_deframer.sv | 99 +++++++++
 tb/tb_hdlc_rx_deframer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: HDLC Rx flag/abort detection, zero de-stuffing and octet assembly.
// Optional line idle detector is built only when HDLC_RX_IDLE_EN is defined.
module hdlc_rx_deframer #(
    parameter int ABORT_ONES = 7
`ifdef HDLC_RX_IDLE_EN
    ,
    parameter int IDLE_LEN = 8
`endif
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_FrameActive,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_FrameError,
    output logic       Rx_IdleDetect
);
    localparam int HW = (ABORT_ONES + 1 > 8) ? ABORT_ONES + 1 : 8;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t          r_state, w_state_nx;
    logic [HW-1:0]   r_hist;
    logic [7:0]      r_dly, r_vld;
    logic [6:0]      r_sr;
    logic [2:0]      r_bcnt, r_ones;
    logic            w_flag, w_abort, w_take, w_bit, w_drop;

    // Newest bit sits at the top of the history; the delay line matches it so a flag
    // seen in the history occupies exactly the 8 delay-line slots that get invalidated.
    assign w_flag         = r_hist[HW-1 -: 8] == 8'h7E;
    assign w_abort        = (&r_hist[HW-1 -: ABORT_ONES]) && !r_hist[HW-1-ABORT_ONES];
    assign w_bit          = r_dly[0];
    assign w_take         = r_state == S_ACTIVE && r_vld[0] && !w_flag && !w_abort;
    assign w_drop         = !w_bit && r_ones == 3'd5;
    assign Rx_FrameActive = r_state == S_ACTIVE;

    always_comb begin
        w_state_nx = w_flag ? S_ACTIVE : w_abort ? S_IDLE : r_state;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state        <= S_IDLE;
            r_hist         <= '0;
            r_dly          <= '0;
            r_vld          <= '0;
            r_sr           <= '0;
            r_bcnt         <= '0;
            r_ones         <= '0;
            Rx_Data        <= '0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
            Rx_NewByte     <= 1'b0;
            Rx_FrameError  <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_hist         <= {Rx, r_hist[HW-1:1]};
            r_dly          <= {Rx, r_dly[7:1]};
            r_vld          <= {1'b1, (w_flag || w_abort) ? 7'd0 : r_vld[7:1]};
            Rx_FlagDetect  <= w_flag;
            Rx_AbortDetect <= w_abort;
            Rx_FrameError  <= w_flag && r_state == S_ACTIVE && r_bcnt != 3'd0;
            Rx_NewByte     <= w_take && !w_drop && r_bcnt == 3'd7;
            if (w_flag || w_abort) begin
                r_bcnt <= '0;
                r_ones <= '0;
            end else if (w_take) begin
                r_ones <= !w_bit ? 3'd0 : (r_ones == 3'd6) ? r_ones : r_ones + 3'd1;
                if (!w_drop) begin
                    r_sr   <= {w_bit, r_sr[6:1]};
                    r_bcnt <= r_bcnt + 3'd1;
                    if (r_bcnt == 3'd7)
                        Rx_Data <= {w_bit, r_sr};
                end
            end
        end
    end

`ifdef HDLC_RX_IDLE_EN
    localparam int IW = $clog2(IDLE_LEN + 1);
    logic [IW-1:0] r_icnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_icnt        <= '0;
            Rx_IdleDetect <= 1'b0;
        end else begin
            r_icnt        <= !Rx ? '0 : (r_icnt == IW'(IDLE_LEN)) ? r_icnt : r_icnt + 1'b1;
            Rx_IdleDetect <= r_icnt == IW'(IDLE_LEN);
        end
    end
`else
    assign Rx_IdleDetect = 1'b0;
`endif
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: scoreboard bench for the HDLC Rx deframer.
module tb_hdlc_rx_deframer;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rx  = 1'b0;
    logic       Rx_FlagDetect, Rx_AbortDetect, Rx_FrameActive, Rx_NewByte, Rx_FrameError, Rx_IdleDetect;
    logic [7:0] Rx_Data;

    int n_pass = 0, n_total = 0;
    int n_flag = 0, n_abort = 0, n_err = 0, n_byte = 0;
    int tb_ones = 0;
    logic [7:0] exp_q[$];

    hdlc_rx_deframer dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx),
        .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_FrameActive(Rx_FrameActive), .Rx_Data(Rx_Data), .Rx_NewByte(Rx_NewByte),
        .Rx_FrameError(Rx_FrameError), .Rx_IdleDetect(Rx_IdleDetect)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        #1;
        if (!Rst) begin
            if (Rx_FlagDetect) n_flag++;
            if (Rx_AbortDetect) n_abort++;
            if (Rx_FrameError) begin
                n_err++;
                n_total++;
                if (Rx_FlagDetect === 1'b1) n_pass++;
                else $display("FAIL err_with_flag: Rx_FlagDetect=%b required 1", Rx_FlagDetect);
            end
            if (Rx_NewByte) begin
                n_byte++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_byte: Rx_Data=%h required no byte", Rx_Data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (Rx_Data !== e) $display("FAIL byte: Rx_Data=%h required %h", Rx_Data, e);
                    else n_pass++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic send_bit(input logic b);
        @(negedge Clk);
        Rx = b;
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        tb_ones = 0;
    endtask

    task automatic send_data(input logic b);
        send_bit(b);
        tb_ones = b ? tb_ones + 1 : 0;
        if (tb_ones == 5) begin
            send_bit(1'b0);
            tb_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit push);
        if (push) exp_q.push_back(v);
        for (int i = 0; i < 8; i++) send_data(v[i]);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        Rx  = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        exp_q.delete();
        tb_ones = 0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Rx  = 1'b1;
        @(posedge Clk);
        #1;
        n_total++;
        if ({Rx_FlagDetect, Rx_AbortDetect, Rx_FrameActive, Rx_Data, Rx_NewByte, Rx_FrameError, Rx_IdleDetect} !== 14'd0)
            $display("FAIL reset_outputs: got %b required 0", {Rx_FlagDetect, Rx_AbortDetect, Rx_FrameActive, Rx_Data, Rx_NewByte, Rx_FrameError, Rx_IdleDetect});
        else n_pass++;
    endtask

    task automatic test_flag_abort();
        do_reset();
        send_flag();
        @(posedge Clk); #1;
        Rx = 1'b1;
        n_total++;
        if (Rx_FlagDetect !== 1'b0) $display("FAIL flag_early: got %b required 0", Rx_FlagDetect); else n_pass++;
        @(posedge Clk); #1;
        n_total++;
        if (Rx_FlagDetect !== 1'b1) $display("FAIL flag_pulse: got %b required 1", Rx_FlagDetect); else n_pass++;
        n_total++;
        if (Rx_FrameActive !== 1'b1) $display("FAIL active_on_flag: got %b required 1", Rx_FrameActive); else n_pass++;
        @(posedge Clk); #1;
        n_total++;
        if (Rx_FlagDetect !== 1'b0) $display("FAIL flag_one_cycle: got %b required 0", Rx_FlagDetect); else n_pass++;
        repeat (5) @(posedge Clk);
        #1;
        n_total++;
        if ({Rx_AbortDetect, Rx_FrameActive} !== 2'b01) $display("FAIL abort_early: abort/active=%b required 01", {Rx_AbortDetect, Rx_FrameActive}); else n_pass++;
        @(posedge Clk); #1;
        n_total++;
        if ({Rx_AbortDetect, Rx_FrameActive} !== 2'b10) $display("FAIL abort_pulse: abort/active=%b required 10", {Rx_AbortDetect, Rx_FrameActive}); else n_pass++;
        @(posedge Clk); #1;
        n_total++;
        if (Rx_AbortDetect !== 1'b0) $display("FAIL abort_one_cycle: got %b required 0", Rx_AbortDetect); else n_pass++;
    endtask

    task automatic test_single_byte();
        int f0, b0, e0;
        do_reset();
        f0 = n_flag; b0 = n_byte; e0 = n_err;
        send_flag();
        send_byte(8'hA5, 1'b1);
        send_flag();
        wait_cycles(4);
        n_total++;
        if (n_byte - b0 != 1) $display("FAIL a5_bytes: got %0d required 1", n_byte - b0); else n_pass++;
        n_total++;
        if (n_flag - f0 != 2) $display("FAIL a5_flags: got %0d required 2", n_flag - f0); else n_pass++;
        n_total++;
        if (n_err - e0 != 0) $display("FAIL a5_error: got %0d required 0", n_err - e0); else n_pass++;
    endtask

    task automatic test_stuffing();
        int b0, a0;
        do_reset();
        b0 = n_byte; a0 = n_abort;
        send_flag();
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        send_flag();
        wait_cycles(4);
        n_total++;
        if (n_byte - b0 != 2) $display("FAIL stuff_bytes: got %0d required 2", n_byte - b0); else n_pass++;
        n_total++;
        if (n_abort - a0 != 0) $display("FAIL stuff_abort: got %0d required 0", n_abort - a0); else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL stuff_pending: got %0d required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_abort_frame();
        int b0, a0;
        do_reset();
        b0 = n_byte; a0 = n_abort;
        send_flag();
        send_byte(8'h12, 1'b1);
        send_bit(1'b0);
        repeat (7) send_bit(1'b1);
        @(posedge Clk); #1;
        n_total++;
        if (Rx_AbortDetect !== 1'b0) $display("FAIL abort12_early: got %b required 0", Rx_AbortDetect); else n_pass++;
        @(posedge Clk); #1;
        n_total++;
        if ({Rx_AbortDetect, Rx_FrameActive} !== 2'b10) $display("FAIL abort12_pulse: abort/active=%b required 10", {Rx_AbortDetect, Rx_FrameActive}); else n_pass++;
        wait_cycles(12);
        n_total++;
        if (n_byte - b0 != 1) $display("FAIL abort12_bytes: got %0d required 1", n_byte - b0); else n_pass++;
        n_total++;
        if (n_abort - a0 != 1) $display("FAIL abort12_count: got %0d required 1", n_abort - a0); else n_pass++;
    endtask

    task automatic test_frame_error();
        int b0, e0;
        logic [3:0] tail;
        do_reset();
        b0 = n_byte; e0 = n_err;
        tail = 4'b0101;
        send_flag();
        send_byte(8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) send_data(tail[i]);
        send_flag();
        wait_cycles(4);
        n_total++;
        if (n_err - e0 != 1) $display("FAIL ferr_count: got %0d required 1", n_err - e0); else n_pass++;
        n_total++;
        if (n_byte - b0 != 1) $display("FAIL ferr_bytes: got %0d required 1", n_byte - b0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int f0, b0, e0;
        logic [14:0] seq;
        do_reset();
        f0 = n_flag; b0 = n_byte; e0 = n_err;
        seq = 15'b011111101111110;
        for (int i = 14; i >= 0; i--) send_bit(seq[i]);
        wait_cycles(3);
        n_total++;
        if (n_flag - f0 != 2) $display("FAIL shared_zero_flags: got %0d required 2", n_flag - f0); else n_pass++;
        n_total++;
        if (n_err - e0 != 0 || n_byte - b0 != 0) $display("FAIL empty_frame: err=%0d bytes=%0d required 0 0", n_err - e0, n_byte - b0); else n_pass++;
        b0 = n_byte;
        send_flag();
        for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_flag();
        wait_cycles(4);
        n_total++;
        if (n_byte - b0 != 4) $display("FAIL b2b_bytes: got %0d required 4", n_byte - b0); else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL b2b_pending: got %0d required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_idle_reset();
        int b0;
        logic [11:0] junk;
        do_reset();
`ifdef HDLC_RX_IDLE_EN
        repeat (8) send_bit(1'b1);
        @(posedge Clk); #1;
        n_total++;
        if (Rx_IdleDetect !== 1'b0) $display("FAIL idle_early: got %b required 0", Rx_IdleDetect); else n_pass++;
        @(posedge Clk); #1;
        n_total++;
        if (Rx_IdleDetect !== 1'b1) $display("FAIL idle_set: got %b required 1", Rx_IdleDetect); else n_pass++;
        send_bit(1'b0);
        @(posedge Clk); #1;
        n_total++;
        if (Rx_IdleDetect !== 1'b1) $display("FAIL idle_hold: got %b required 1", Rx_IdleDetect); else n_pass++;
        @(posedge Clk); #1;
        n_total++;
        if (Rx_IdleDetect !== 1'b0) $display("FAIL idle_clear: got %b required 0", Rx_IdleDetect); else n_pass++;
`else
        repeat (10) send_bit(1'b1);
        wait_cycles(2);
        n_total++;
        if (Rx_IdleDetect !== 1'b0) $display("FAIL idle_tied: got %b required 0", Rx_IdleDetect); else n_pass++;
`endif
        do_reset();
        junk = 12'hB6D;
        send_flag();
        for (int i = 0; i < 12; i++) send_data(junk[i]);
        @(posedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        n_total++;
        if ({Rx_FlagDetect, Rx_AbortDetect, Rx_FrameActive, Rx_Data, Rx_NewByte, Rx_FrameError, Rx_IdleDetect} !== 14'd0)
            $display("FAIL async_reset: got %b required 0", {Rx_FlagDetect, Rx_AbortDetect, Rx_FrameActive, Rx_Data, Rx_NewByte, Rx_FrameError, Rx_IdleDetect});
        else n_pass++;
        @(negedge Clk);
        Rst = 1'b0;
        Rx  = 1'b0;
        exp_q.delete();
        tb_ones = 0;
        b0 = n_byte;
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b0);
        wait_cycles(10);
        n_total++;
        if (n_byte - b0 != 0) $display("FAIL post_reset_nobyte: got %0d required 0", n_byte - b0); else n_pass++;
        send_flag();
        send_byte(8'hC3, 1'b1);
        send_flag();
        wait_cycles(4);
        n_total++;
        if (n_byte - b0 != 1) $display("FAIL post_reset_byte: got %0d required 1", n_byte - b0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_flag_abort();
        test_single_byte();
        test_stuffing();
        test_abort_frame();
        test_frame_error();
        test_back_to_back();
        test_idle_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
